// File: rtl/brc_iter_if.sv
// Request/response bundle between a branch unit and the iterative comparator.
interface brc_iter_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic [2:0]       br_op;
  logic             resp_valid;
  logic             resp_ready;
  logic             br_less;
  logic             br_equal;
  logic             br_taken;
  logic             br_illegal;
  logic             busy;

  modport master (
    output req_valid, rs1_data, rs2_data, br_op, resp_ready,
    input  req_ready, resp_valid, br_less, br_equal, br_taken, br_illegal, busy
  );

  modport slave (
    input  req_valid, rs1_data, rs2_data, br_op, resp_ready,
    output req_ready, resp_valid, br_less, br_equal, br_taken, br_illegal, busy
  );
endinterface

// File: rtl/brc_iter.sv
// Iterative branch comparator: walks operands MSB slice first, stops on the first difference.
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   CMP   | comparing slice k, one slice per cycle
//   DONE  | result held on the response channel until resp_ready
module brc_iter #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic      clk,
  input logic      rst,
  brc_iter_if.slave bus
);
  localparam int NS = WIDTH / SLICE;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(NS - 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic [KW-1:0]    k_q;
  logic             less_q, equal_q, taken_q, illegal_q;
  logic             accept, finish;
  logic             less_d, equal_d, taken_d, illegal_d;
  logic [SLICE-1:0] a_sl, b_sl;

  // Flipping the sign bit of the top slice turns two's-complement order into unsigned order.
  always_comb begin
    a_sl = a_q[int'(k_q)*SLICE +: SLICE];
    b_sl = b_q[int'(k_q)*SLICE +: SLICE];
    if (k_q == K_TOP && !op_q[1]) begin
      a_sl[SLICE-1] = ~a_sl[SLICE-1];
      b_sl[SLICE-1] = ~b_sl[SLICE-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    finish         = 1'b0;
    less_d         = less_q;
    equal_d        = equal_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.busy       = 1'b1;
    case (state_q)
      IDLE: begin
        bus.busy      = 1'b0;
        bus.req_ready = !rst;
        if (bus.req_valid && !rst) begin
          accept  = 1'b1;
          state_d = CMP;
        end
      end
      CMP: begin
        if (a_sl != b_sl) begin
          finish  = 1'b1;
          less_d  = (a_sl < b_sl);
          equal_d = 1'b0;
          state_d = DONE;
        end else if (k_q == '0) begin
          finish  = 1'b1;
          less_d  = 1'b0;
          equal_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    illegal_d = (op_q[2:1] == 2'b01);
    case (op_q)
      3'b000:          taken_d = equal_d;
      3'b001:          taken_d = !equal_d;
      3'b100, 3'b110:  taken_d = less_d;
      3'b101, 3'b111:  taken_d = !less_d;
      default:         taken_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      k_q       <= K_TOP;
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= bus.rs1_data;
        b_q  <= bus.rs2_data;
        op_q <= bus.br_op;
        k_q  <= K_TOP;
      end else if (state_q == CMP && !finish) begin
        k_q <= k_q - KW'(1);
      end
      if (finish) begin
        less_q    <= less_d;
        equal_q   <= equal_d;
        taken_q   <= taken_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign bus.br_less    = less_q;
  assign bus.br_equal   = equal_q;
  assign bus.br_taken   = taken_q;
  assign bus.br_illegal = illegal_q;
endmodule

// File: tb/tb_brc_iter.sv
// Randomized bench for brc_iter: 4-slice and single-slice instances against an arithmetic reference model.
module tb_brc_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  brc_iter_if #(.WIDTH(32)) ifa ();
  brc_iter_if #(.WIDTH(32)) ifb ();

  brc_iter #(.WIDTH(32), .SLICE(8))  u_dut    (.clk(clk), .rst(rst), .bus(ifa.slave));
  brc_iter #(.WIDTH(32), .SLICE(32)) u_dut_1c (.clk(clk), .rst(rst), .bus(ifb.slave));

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lat_model(input logic [31:0] a, input logic [31:0] b, input int ns);
    int sl = 32 / ns;
    longint unsigned mask = (64'd1 << sl) - 64'd1;
    int m = ns;
    bit found = 0;
    for (int i = ns - 1; i >= 0; i--) begin
      if (!found && (((64'(a) >> (i * sl)) & mask) != ((64'(b) >> (i * sl)) & mask))) begin
        m = ns - i;
        found = 1;
      end
    end
    return m;
  endfunction

  function automatic logic [3:0] flag_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    bit less, eq, tk, ill;
    eq   = (a == b);
    less = op[1] ? (a < b) : ($signed(a) < $signed(b));
    ill  = (op == 3'b010) || (op == 3'b011);
    case (op)
      3'b000:         tk = eq;
      3'b001:         tk = !eq;
      3'b100, 3'b110: tk = less;
      3'b101, 3'b111: tk = !less;
      default:        tk = 0;
    endcase
    return {less, eq, tk, ill};
  endfunction

  task automatic run(virtual brc_iter_if #(.WIDTH(32)) vif, input int ns,
                     input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                     input int hold, input int exp_m);
    logic [3:0] exp_f, snap;
    int cnt;
    exp_f = flag_model(a, b, op);
    chk("req_ready_idle", vif.req_ready, 1);
    vif.req_valid  = 1'b1;
    vif.rs1_data   = a;
    vif.rs2_data   = b;
    vif.br_op      = op;
    vif.resp_ready = 1'b0;
    @(posedge clk); #1;
    vif.req_valid = 1'b0;
    cnt = 0;
    while (!vif.resp_valid && cnt < 64) begin
      chk("cmp_busy_ready", {vif.busy, vif.req_ready}, 2'b10);
      vif.rs1_data  = $urandom;
      vif.rs2_data  = $urandom;
      vif.br_op     = 3'($urandom);
      vif.req_valid = 1'($urandom);
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", cnt, (exp_m >= 0) ? exp_m : lat_model(a, b, ns));
    chk("flags", {vif.br_less, vif.br_equal, vif.br_taken, vif.br_illegal}, exp_f);
    snap = {vif.br_less, vif.br_equal, vif.br_taken, vif.br_illegal};
    repeat (hold) begin
      vif.rs1_data  = $urandom;
      vif.rs2_data  = $urandom;
      vif.req_valid = 1'($urandom);
      @(posedge clk); #1;
      chk("hold", {vif.resp_valid, vif.req_ready, vif.busy,
                   vif.br_less, vif.br_equal, vif.br_taken, vif.br_illegal},
          {3'b101, snap});
    end
    vif.resp_ready = 1'b1;
    @(posedge clk); #1;
    vif.resp_ready = 1'b0;
    vif.req_valid  = 1'b0;
    chk("after_hs", {vif.resp_valid, vif.busy, vif.req_ready}, 3'b001);
    chk("flags_kept", {vif.br_less, vif.br_equal, vif.br_taken, vif.br_illegal}, exp_f);
  endtask

  initial begin
    logic [31:0] a, b;
    ifa.req_valid = 0; ifa.rs1_data = 0; ifa.rs2_data = 0; ifa.br_op = 0; ifa.resp_ready = 0;
    ifb.req_valid = 0; ifb.rs1_data = 0; ifb.rs2_data = 0; ifb.br_op = 0; ifb.resp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {ifa.resp_valid, ifa.busy, ifa.req_ready, ifa.br_less,
                        ifa.br_equal, ifa.br_taken, ifa.br_illegal}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", {ifa.req_ready, ifb.req_ready}, 2'b11);

    run(ifa, 4, 32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 0, 4);
    run(ifa, 4, 32'hDEADBEEF, 32'hDEADBEEF, 3'b001, 0, 4);
    run(ifa, 4, 32'hFFFFFFFF, 32'h00000001, 3'b100, 0, 1);
    run(ifa, 4, 32'hFFFFFFFF, 32'h00000001, 3'b110, 0, 1);
    run(ifa, 4, 32'h12345600, 32'h12345601, 3'b111, 0, 4);
    run(ifa, 4, 32'h12345600, 32'h12345601, 3'b101, 0, 4);
    run(ifa, 4, 32'h80AB1234, 32'h80AC0000, 3'b100, 5, 2);
    run(ifa, 4, 32'h00000000, 32'h00000000, 3'b000, 0, 4);

    // async reset in the 2nd CMP cycle, with flags still holding the previous equal/taken result
    ifa.req_valid = 1'b1;
    ifa.rs1_data  = 32'hCAFEF00D;
    ifa.rs2_data  = 32'hCAFEF00D;
    ifa.br_op     = 3'b000;
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("busy_before_rst", ifa.busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_async", {ifa.resp_valid, ifa.busy, ifa.req_ready, ifa.br_less,
                      ifa.br_equal, ifa.br_taken, ifa.br_illegal}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst2", {ifa.req_ready, ifa.busy, ifa.resp_valid}, 3'b100);

    run(ifa, 4, 32'h13579BDF, 32'h13579BDF, 3'b010, 0, 4);
    run(ifa, 4, 32'h00000005, 32'hF0000009, 3'b011, 1, 1);

    run(ifb, 1, 32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 0, 1);
    run(ifb, 1, 32'hFFFFFFFF, 32'h00000001, 3'b100, 2, 1);
    run(ifb, 1, 32'hFFFFFFFF, 32'h00000001, 3'b110, 0, 1);

    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      case ($urandom % 4)
        0:       b = $urandom;
        1:       b = a;
        2:       b = a ^ (32'd1 << ($urandom % 32));
        default: b = a ^ ($urandom & ((32'd1 << ($urandom % 32)) - 32'd1));
      endcase
      run(ifa, 4, a, b, 3'($urandom), int'($urandom % 3), -1);
    end

    for (int i = 0; i < 10000; i++) begin
      a = $urandom;
      case ($urandom % 4)
        0:       b = $urandom;
        1:       b = a;
        2:       b = a ^ (32'd1 << ($urandom % 32));
        default: b = {~a[31], a[30:0]};
      endcase
      run(ifb, 1, a, b, 3'($urandom), 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/brc_iter.md
# brc_iter

Iterative, parametrised branch comparator for the multi-cycle core datapath: accepts two operands and a RISC-V branch funct3 over a valid/ready request, then compares them most-significant slice first, SLICE bits per cycle. It terminates early on the first differing slice. It returns less/equal flags plus a resolved branch-taken decision over a valid/ready response channel. It replaces the single-cycle comparator wherever WIDTH exceeds what a single-cycle compare can close timing on.

## Interface
- WIDTH, 32: operand width in bits.
- SLICE, 8: bits compared per cycle.
  - WIDTH % SLICE must be 0.
  - NS = WIDTH/SLICE is the slice count.
  - SLICE = WIDTH gives a single compare cycle.
- clk  in  1  clock, rising edge.
- rst  in  1  reset: asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- rs1_data  in  WIDTH  operand A.
- rs2_data  in  WIDTH  operand B.
- br_op  in  3  funct3 encoding:
  - 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - 010 and 011 are illegal.
- resp_valid  out  1  result present.
- resp_ready  in  1  consumer accepts the result.
- br_less  out  1  A < B; signed when br_op[1]=0, unsigned when br_op[1]=1.
- br_equal  out  1  A == B.
- br_taken  out  1  branch condition true for the captured br_op.
- br_illegal  out  1  captured br_op was 010 or 011.
- busy  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture rs1_data, rs2_data and br_op into internal registers; set slice index k=NS-1; go to CMP.
  - Inputs are don't-care after the capture edge.
- CMP: each cycle, compare slice k (bits [k*SLICE+SLICE-1 : k*SLICE]) of A and B.
  - Slices differ: latch br_less, latch br_equal=0, go to DONE.
  - Slices equal and k==0: latch br_less=0, latch br_equal=1, go to DONE.
  - Otherwise decrement k and stay in CMP.
  - Slice ordering is unsigned, except the top slice (k=NS-1) in signed mode: invert the MSB of both A and B before comparing.
- DONE:
  - resp_valid=1.
  - br_less, br_equal, br_taken and br_illegal stay stable until resp_ready.
  - On resp_valid&&resp_ready, go to IDLE.
  - req_ready=0 in DONE: no same-cycle turnaround.
- br_taken:
  - BEQ: equal.
  - BNE: !equal.
  - BLT / BLTU: less.
  - BGE / BGEU: !less.
  - Illegal op: br_taken=0, br_illegal=1. br_less and br_equal are still computed, using unsigned compare (br_op[1]=1).
- br_less, br_equal, br_taken and br_illegal are registered. Outside DONE they hold their last values, but they are valid only while resp_valid=1.

## Timing
- Reset (async assert, any state, including mid-CMP or in DONE):
  - State goes to IDLE; any in-flight request is discarded.
  - resp_valid=0, br_less=0, br_equal=0, br_taken=0, br_illegal=0, busy=0, k=NS-1.
  - req_ready=1 once rst is released.
- Latency: accept at edge E0; m slices are examined (1 ≤ m ≤ NS); resp_valid rises after edge E0+m.
  - m = 1 + (number of leading equal slices), capped at NS.
  - Equal operands always take NS cycles.
- Throughput: minimum request spacing is m+2 edges (accept, m compare cycles, response handshake).
- Backpressure: with resp_ready=0, DONE is held indefinitely and outputs do not change.
- A request presented while busy=1 is not accepted. req_ready=0 signals this; the requester holds it.

## Test plan
- **Equal operands:** WIDTH=32, SLICE=8, A=B=0xDEADBEEF, BEQ.
  - resp_valid rises 4 edges after accept.
  - br_equal=1, br_less=0, br_taken=1.
  - Same operands with BNE: br_taken=0.
- **Signed vs unsigned at the top slice:** A=0xFFFFFFFF, B=0x00000001.
  - BLT: 1-cycle latency, br_less=1, br_taken=1.
  - BLTU: 1-cycle latency, br_less=0, br_taken=0.
- **Difference only in the low slice:** A=0x12345600, B=0x12345601, BGEU.
  - 4-cycle latency, br_less=1, br_equal=0, br_taken=0.
  - Same operands with BGE: br_taken=0.
- **Backpressure and input hold:** change rs1_data/rs2_data every cycle after accept; hold resp_ready=0 for 5 cycles in DONE.
  - Result reflects the captured values.
  - Outputs stay stable and req_ready=0 throughout.
  - Handshake completes on the first resp_ready=1; IDLE follows.
- **Async reset mid-CMP and illegal op:**
  - Assert rst on the 2nd CMP cycle of an equal compare: all outputs go to 0 immediately; after release, req_ready=1.
  - Then br_op=010 with A=B: br_illegal=1, br_taken=0, br_equal=1.
- **Single-cycle configuration:** SLICE=WIDTH=32.
  - Every compare completes with latency 1.
  - Random signed/unsigned ops match a reference model over 10k vectors.
